// File: rtl/wshb_ram_slave.sv
// wshb_ram_slave: Wishbone B4 RAM slave with linear bursts; define WSHB_RAM_ERR_EN for range/alignment err.
module wshb_ram_slave #(
   parameter int DATA_BYTES = 4,
   parameter int ADR_W      = 32,
   parameter int MEM_WORDS  = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cyc,
   input  logic                    stb,
   input  logic [ADR_W-1:0]        adr,
   input  logic                    we,
   input  logic [8*DATA_BYTES-1:0] dat_ms,
   input  logic [DATA_BYTES-1:0]   sel,
   input  logic [2:0]              cti,
   input  logic [1:0]              bte,
   output logic [8*DATA_BYTES-1:0] dat_sm,
   output logic                    ack,
   output logic                    err,
   output logic                    rty
);
   localparam int DW = 8*DATA_BYTES;
   localparam int BW = $clog2(DATA_BYTES);
   localparam int IW = $clog2(MEM_WORDS);
   typedef enum logic {IDLE, BURST} state_t;
   state_t state, state_n;
   logic [IW-1:0] ptr, ptr_n, aidx, ridx;
   logic [DW-1:0] mem [MEM_WORDS];
   logic [DW-1:0] rdata, dat_n;
   logic ack_n, err_n, go, wr, bad, last;
   assign go = cyc & stb;
   assign aidx = adr[BW +: IW];
   assign wr = ack & go & we & ~rst;
   assign rty = 1'b0;
   assign ridx = state == IDLE ? aidx : ptr + IW'(1);
`ifdef WSHB_RAM_ERR_EN
   assign bad = adr >= ADR_W'(MEM_WORDS*DATA_BYTES) || (adr & ADR_W'(DATA_BYTES-1)) != '0;
   assign last = &ptr;
`else
   logic unused;
   assign unused = ^adr;
   assign bad = 1'b0;
   assign last = 1'b0;
`endif
   // a write landing on the word being fetched this edge is forwarded
   always_comb begin
      rdata = mem[ridx];
      for (int i = 0; i < DATA_BYTES; i++)
         if (wr && sel[i] && aidx == ridx) rdata[8*i +: 8] = dat_ms[8*i +: 8];
   end
   always_comb begin
      state_n = IDLE;
      ptr_n = ptr;
      ack_n = 1'b0;
      err_n = 1'b0;
      dat_n = '0;
      if (state == IDLE && go && !ack && !err) begin
         ptr_n = aidx;
         err_n = bad;
         ack_n = !bad;
         dat_n = bad ? '0 : rdata;
         state_n = (!bad && cti == 3'b010 && bte == 2'b00) ? BURST : IDLE;
      end else if (state == BURST && ack && go && cti == 3'b010) begin
         ptr_n = ptr + IW'(1);
         err_n = last;
         ack_n = !last;
         dat_n = last ? '0 : rdata;
         state_n = last ? IDLE : BURST;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         ack <= 1'b0;
         err <= 1'b0;
         dat_sm <= '0;
      end else begin
         state <= state_n;
         ptr <= ptr_n;
         ack <= ack_n;
         err <= err_n;
         dat_sm <= dat_n;
      end
   end
   always_ff @(posedge clk)
      for (int i = 0; i < DATA_BYTES; i++)
         if (wr && sel[i]) mem[aidx][8*i +: 8] <= dat_ms[8*i +: 8];
endmodule
